// File: rtl/ex_arith_pipe.sv
// Add/subtract/set-less-than unit with a STAGES-deep elastic pipeline.
// Arithmetic resolves in stage 1; later stages only carry result, flags and tag.
module ex_arith_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAGW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] reg1_i,
    input  logic [WIDTH-1:0] reg2_i,
    input  logic [TAGW-1:0]  tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] wdata_o,
    output logic             wreg_o,
    output logic [TAGW-1:0]  tag_o,
    output logic             ov_o,
    output logic             ill_o
);

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpAddu = 3'd1;
    localparam logic [2:0] OpSub  = 3'd2;
    localparam logic [2:0] OpSubu = 3'd3;
    localparam logic [2:0] OpSlt  = 3'd4;
    localparam logic [2:0] OpSltu = 3'd5;
    localparam int unsigned Last  = STAGES - 1;

    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             ov_raw;
    logic             sltu;

    logic [WIDTH-1:0] res_wdata;
    logic             res_wreg;
    logic             res_ov;
    logic             res_ill;

    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  wdata_q [STAGES];
    logic              wreg_q  [STAGES];
    logic              ov_q    [STAGES];
    logic              ill_q   [STAGES];
    logic [TAGW-1:0]   tag_q   [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] move;
    logic              downstream_full;

    // Stage-1 arithmetic
    assign sub_op = (op_i == OpSub) || (op_i == OpSubu) || (op_i == OpSlt) || (op_i == OpSltu);
    assign b_eff  = sub_op ? (~reg2_i) + WIDTH'(1) : reg2_i;
    assign sum    = reg1_i + b_eff;
    assign ov_raw = (reg1_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != reg1_i[WIDTH-1]);
    assign sltu   = reg1_i < reg2_i;

    always_comb begin
        res_wdata = '0;
        res_wreg  = 1'b0;
        res_ov    = 1'b0;
        res_ill   = 1'b0;
        case (op_i)
            OpAdd, OpSub: begin
                res_wdata = sum;
                res_wreg  = ~ov_raw;
                res_ov    = ov_raw;
            end
            OpAddu, OpSubu: begin
                res_wdata = sum;
                res_wreg  = 1'b1;
            end
            OpSlt: begin
                res_wdata = WIDTH'(sum[WIDTH-1] ^ ov_raw);
                res_wreg  = 1'b1;
            end
            OpSltu: begin
                res_wdata = WIDTH'(sltu);
                res_wreg  = 1'b1;
            end
            default: res_ill = 1'b1;
        endcase
    end

    // A stage advances when every occupied stage below the output has room opening up,
    // i.e. the consumer is ready or some later stage is empty.
    always_comb begin
        adv             = '0;
        move            = '0;
        downstream_full = 1'b1;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            adv[i]          = out_ready_i || !downstream_full;
            move[i]         = !v_q[i] || adv[i];
            downstream_full = downstream_full && v_q[i];
        end
    end

    assign in_ready_o = !rst && !flush_i && move[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                wdata_q[i] <= '0;
                wreg_q[i]  <= 1'b0;
                ov_q[i]    <= 1'b0;
                ill_q[i]   <= 1'b0;
                tag_q[i]   <= '0;
            end
        end else begin
            if (move[0]) begin
                v_q[0]     <= in_valid_i && !flush_i;
                wdata_q[0] <= res_wdata;
                wreg_q[0]  <= res_wreg;
                ov_q[0]    <= res_ov;
                ill_q[0]   <= res_ill;
                tag_q[0]   <= tag_i;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (move[i]) begin
                    v_q[i]     <= v_q[i-1] && !flush_i;
                    wdata_q[i] <= wdata_q[i-1];
                    wreg_q[i]  <= wreg_q[i-1];
                    ov_q[i]    <= ov_q[i-1];
                    ill_q[i]   <= ill_q[i-1];
                    tag_q[i]   <= tag_q[i-1];
                end
            end
            if (flush_i) begin
                v_q <= '0;
            end
        end
    end

    // Payload is masked so an empty output stage always reads as zero.
    assign out_valid_o = v_q[Last];
    assign wdata_o     = v_q[Last] ? wdata_q[Last] : '0;
    assign wreg_o      = v_q[Last] && wreg_q[Last];
    assign ov_o        = v_q[Last] && ov_q[Last];
    assign ill_o       = v_q[Last] && ill_q[Last];
    assign tag_o       = v_q[Last] ? tag_q[Last] : '0;

endmodule

// File: tb/tb_ex_arith_pipe.sv
// Randomized bench for ex_arith_pipe: a queue-based reference model predicts every
// result, handshake and latency; a second 8-bit single-stage instance covers opcode 7.
module tb_ex_arith_pipe;

    localparam int unsigned W = 32;
    localparam int unsigned S = 2;
    localparam int unsigned T = 5;

    typedef struct {
        logic [63:0] wdata;
        logic        wreg;
        logic        ov;
        logic        ill;
        logic [4:0]  tag;
        int          acc;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] reg1;
    logic [W-1:0] reg2;
    logic [T-1:0] tag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] wdata;
    logic         wreg;
    logic [T-1:0] tag_o;
    logic         ov;
    logic         ill;

    logic         in_valid8;
    logic         in_ready8;
    logic [2:0]   op8;
    logic [7:0]   reg1_8;
    logic [7:0]   reg2_8;
    logic [T-1:0] tag8;
    logic         out_valid8;
    logic [7:0]   wdata8;
    logic         wreg8;
    logic [T-1:0] tag8_o;
    logic         ov8;
    logic         ill8;
    logic         flush8;
    logic         out_ready8;

    int   n_vec;
    int   n_err;
    int   cyc;
    exp_t q[$];

    ex_arith_pipe #(.WIDTH(W), .STAGES(S), .TAGW(T)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .op_i       (op),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .tag_i      (tag),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .wdata_o    (wdata),
        .wreg_o     (wreg),
        .tag_o      (tag_o),
        .ov_o       (ov),
        .ill_o      (ill)
    );

    ex_arith_pipe #(.WIDTH(8), .STAGES(1), .TAGW(T)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush8),
        .in_valid_i (in_valid8),
        .in_ready_o (in_ready8),
        .op_i       (op8),
        .reg1_i     (reg1_8),
        .reg2_i     (reg2_8),
        .tag_i      (tag8),
        .out_valid_o(out_valid8),
        .out_ready_i(out_ready8),
        .wdata_o    (wdata8),
        .wreg_o     (wreg8),
        .tag_o      (tag8_o),
        .ov_o       (ov8),
        .ill_o      (ill8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on signed/unsigned interpretations.
    function automatic exp_t model(input int opc, input longint a, input longint b, input int w);
        exp_t   e;
        longint mask;
        longint sa;
        longint sb;
        longint s;
        longint lo;
        longint hi;
        mask = (longint'(1) <<< w) - 1;
        lo   = -(longint'(1) <<< (w - 1));
        hi   = -lo - 1;
        a    = a & mask;
        b    = b & mask;
        sa   = a[w-1] ? a - (mask + 1) : a;
        sb   = b[w-1] ? b - (mask + 1) : b;
        e.wdata = '0;
        e.wreg  = 1'b0;
        e.ov    = 1'b0;
        e.ill   = 1'b0;
        e.tag   = '0;
        e.acc   = 0;
        case (opc)
            0: begin
                s       = sa + sb;
                e.wdata = (a + b) & mask;
                e.ov    = (s < lo) || (s > hi);
                e.wreg  = !e.ov;
            end
            1: begin e.wdata = (a + b) & mask; e.wreg = 1'b1; end
            2: begin
                s       = sa - sb;
                e.wdata = (a - b) & mask;
                e.ov    = (s < lo) || (s > hi);
                e.wreg  = !e.ov;
            end
            3: begin e.wdata = (a - b) & mask; e.wreg = 1'b1; end
            4: begin e.wdata = (sa < sb) ? 64'd1 : 64'd0; e.wreg = 1'b1; end
            5: begin e.wdata = (a < b) ? 64'd1 : 64'd0; e.wreg = 1'b1; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // One cycle: drive just after negedge, check predicted handshake/outputs, then clock.
    task automatic step(input bit v, input int opc, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [T-1:0] tg, input bit ordy, input bit fl, output bit accepted);
        exp_t e;
        bit   exp_rdy;
        bit   exp_ov;
        bit   xfer;
        in_valid  = v;
        op        = opc[2:0];
        reg1      = a;
        reg2      = b;
        tag       = tg;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !fl && ((q.size() < S) || ordy);
        check("in_ready", in_ready, exp_rdy);
        // The oldest entry never waits behind anything, so it reaches the output after S edges.
        exp_ov = (q.size() > 0) && (cyc - q[0].acc + 1 >= S);
        check("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            check("wdata", wdata, q[0].wdata);
            check("wreg", wreg, q[0].wreg);
            check("ov", ov, q[0].ov);
            check("ill", ill, q[0].ill);
            check("tag", tag_o, q[0].tag);
        end else begin
            check("idle_outs", {wdata, wreg, ov, ill, tag_o}, 64'd0);
        end
        accepted = v && exp_rdy;
        xfer     = exp_ov && ordy && !fl;
        @(posedge clk);
        cyc++;
        if (fl) begin
            q.delete();
        end else begin
            if (xfer) void'(q.pop_front());
            if (accepted) begin
                e     = model(opc, longint'(a), longint'(b), W);
                e.tag = tg;
                e.acc = cyc;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, acc);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] special [5];
        special[0] = 32'h0000_0000;
        special[1] = 32'h0000_0001;
        special[2] = 32'h7FFF_FFFF;
        special[3] = 32'h8000_0000;
        special[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return special[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        bit           acc;
        int           sent;
        int           opc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e8;

        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; reg1 = '0; reg2 = '0; tag = '0;
        out_ready = 1'b1;
        in_valid8 = 1'b0; op8 = '0; reg1_8 = '0; reg2_8 = '0; tag8 = '0;
        flush8 = 1'b0; out_ready8 = 1'b1;

        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_outs", {wdata, wreg, ov, ill, tag_o}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Directed arithmetic corners
        step(1'b1, 0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd1, 1'b1, 1'b0, acc);
        step(1'b1, 3, 32'h0000_0000, 32'h0000_0001, 5'd2, 1'b1, 1'b0, acc);
        step(1'b1, 4, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3, 1'b1, 1'b0, acc);
        step(1'b1, 5, 32'hFFFF_FFFF, 32'h0000_0001, 5'd4, 1'b1, 1'b0, acc);
        step(1'b1, 2, 32'h8000_0000, 32'h0000_0001, 5'd5, 1'b1, 1'b0, acc);
        step(1'b1, 6, 32'h1234_5678, 32'h0000_0001, 5'd6, 1'b1, 1'b0, acc);
        idle(3);

        // Eight back-to-back ops with the consumer stalled for cycles 3-6
        sent = 0;
        for (int c = 0; c < 30 && sent < 8; c++) begin
            step(1'b1, $urandom_range(0, 5), pick_operand(), 32'h0000_0003, T'(8 + sent),
                 !(c >= 3 && c <= 6), 1'b0, acc);
            if (acc) sent++;
        end
        check("stall_all_sent", 64'(sent), 64'd8);
        idle(5);

        // Flush with two ops in flight and a same-cycle input
        step(1'b1, 1, 32'd10, 32'd20, 5'd20, 1'b1, 1'b0, acc);
        step(1'b1, 1, 32'd30, 32'd40, 5'd21, 1'b1, 1'b0, acc);
        step(1'b1, 1, 32'd50, 32'd60, 5'd22, 1'b1, 1'b1, acc);
        step(1'b1, 1, 32'd70, 32'd80, 5'd23, 1'b1, 1'b0, acc);
        idle(4);

        // Asynchronous reset between edges with operations in flight
        step(1'b1, 0, 32'd1, 32'd2, 5'd24, 1'b1, 1'b0, acc);
        step(1'b1, 0, 32'd3, 32'd4, 5'd25, 1'b1, 1'b0, acc);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_outs", {wdata, wreg, ov, ill, tag_o}, 64'd0);
        q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        idle(4);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            opc = $urandom_range(0, 7);
            a   = pick_operand();
            b   = pick_operand();
            // Negating the most-negative value has no signed representation; keep it out.
            if ((opc == 2 || opc == 4) && b == 32'h8000_0000) b = 32'h8000_0001;
            step($urandom_range(0, 3) != 0, opc, a, b, T'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 39) == 0, acc);
        end
        idle(5);

        // 8-bit, single-stage instance: illegal opcode then a signed overflow
        in_valid8 = 1'b1; op8 = 3'd7; reg1_8 = 8'h55; reg2_8 = 8'h0F; tag8 = 5'd7;
        @(posedge clk);
        @(negedge clk);
        e8 = model(7, 64'h55, 64'h0F, 8);
        op8 = 3'd0; reg1_8 = 8'h7F; reg2_8 = 8'h01; tag8 = 5'd9;
        #1;
        check("w8_ill_valid", out_valid8, 1'b1);
        check("w8_ill", ill8, e8.ill);
        check("w8_ill_wreg", wreg8, e8.wreg);
        check("w8_ill_wdata", wdata8, e8.wdata);
        check("w8_ill_tag", tag8_o, 5'd7);
        @(posedge clk);
        @(negedge clk);
        e8 = model(0, 64'h7F, 64'h01, 8);
        in_valid8 = 1'b0;
        #1;
        check("w8_add_wdata", wdata8, e8.wdata);
        check("w8_add_ov", ov8, e8.ov);
        check("w8_add_wreg", wreg8, e8.wreg);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("w8_empty", out_valid8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
